// File: rtl/rocket_pool_controller.sv
// Rocket slot allocator: player/alien slot pools, alien scan FSM and the shared launch bus.
// Player launches win the bus; an alien launch waits in LAUNCH until the bus is free.
module rocket_pool_controller #(
  parameter int P_SLOTS      = 2,
  parameter int A_SLOTS      = 4,
  parameter int COLS         = 14,
  parameter int ROWS         = 6,
  parameter int CELL         = 32,
  parameter int PLAYER_SPEED = -128,
  parameter int PLAYER_XOFF  = 32,
  parameter int COOLDOWN     = 8,
  localparam int CW          = $clog2(COLS),
  localparam int RW          = $clog2(ROWS)
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic                playerFire,
  input  logic                shootPulse,
  input  logic [CW-1:0]       randCol,
  input  logic [1:0]          randSpeed,
  input  logic                alienAlive,
  input  logic signed [10:0]  playerTLX,
  input  logic signed [10:0]  playerTLY,
  input  logic signed [10:0]  aliensTLX,
  input  logic signed [10:0]  aliensTLY,
  input  logic [P_SLOTS-1:0]  pRelease,
  input  logic [A_SLOTS-1:0]  aRelease,
  output logic [P_SLOTS-1:0]  isActivePlayers,
  output logic [A_SLOTS-1:0]  isActiveAliens,
  output logic                launchValid,
  output logic                launchIsAlien,
  output logic [2:0]          launchSlot,
  output logic signed [10:0]  initialX,
  output logic signed [10:0]  initialY,
  output logic signed [10:0]  initialSpeed,
  output logic [CW-1:0]       colIdx,
  output logic [RW-1:0]       rowIdx,
  output logic                scanBusy
);

  localparam int NCELLS = COLS * ROWS;
  localparam int VW     = $clog2(NCELLS);
  localparam int CDW    = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int CSH    = $clog2(CELL);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_LAUNCH} state_t;

  state_t               r_state, w_state_next;
  logic [P_SLOTS-1:0]   r_p_active, w_p_set;
  logic [A_SLOTS-1:0]   r_a_active, w_a_set;
  logic [CDW-1:0]       r_cool;
  logic [CW-1:0]        r_col, w_col_next;
  logic [RW-1:0]        r_row, w_row_next;
  logic [VW-1:0]        r_vis, w_vis_next;
  logic                 r_valid, r_is_alien;
  logic [2:0]           r_slot;
  logic signed [10:0]   r_x, r_y, r_speed;
  logic                 w_p_free, w_a_free, w_player_go, w_alien_go;
  logic [2:0]           w_p_slot, w_a_slot;
  logic signed [10:0]   w_ax, w_ay, w_aspeed;

  // Descending loop so the last hit is the lowest free index.
  always_comb begin
    w_p_free = 1'b0;
    w_p_slot = '0;
    for (int i = P_SLOTS - 1; i >= 0; i--) begin
      if (!r_p_active[i]) begin
        w_p_free = 1'b1;
        w_p_slot = 3'(i);
      end
    end
    w_a_free = 1'b0;
    w_a_slot = '0;
    for (int i = A_SLOTS - 1; i >= 0; i--) begin
      if (!r_a_active[i]) begin
        w_a_free = 1'b1;
        w_a_slot = 3'(i);
      end
    end
  end

  assign w_player_go = playerFire && w_p_free && (r_cool == '0);
  assign w_p_set     = w_player_go ? (P_SLOTS'(1) << w_p_slot) : '0;
  assign w_a_set     = w_alien_go  ? (A_SLOTS'(1) << w_a_slot) : '0;

  assign w_ax     = aliensTLX + (11'(r_col) << CSH) + 11'(CELL / 2);
  assign w_ay     = aliensTLY + (11'(r_row) << CSH) + 11'(CELL);
  assign w_aspeed = 11'd32 << randSpeed;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_vis_next   = r_vis;
    w_alien_go   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (shootPulse) begin
          w_col_next   = (randCol > COL_MAX) ? COL_MAX : randCol;
          w_row_next   = ROW_MAX;
          w_vis_next   = '0;
          w_state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        if (alienAlive) begin
          w_state_next = S_LAUNCH;
        end else if (r_vis == VW'(NCELLS - 1)) begin
          w_state_next = S_IDLE;
        end else begin
          w_vis_next = r_vis + 1'b1;
          if (r_row != '0) begin
            w_row_next = r_row - 1'b1;
          end else begin
            w_row_next = ROW_MAX;
            w_col_next = (r_col == COL_MAX) ? '0 : r_col + 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        if (!w_a_free) begin
          w_state_next = S_IDLE;
        end else if (!w_player_go) begin
          w_alien_go   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_p_active <= '0;
      r_a_active <= '0;
      r_cool     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_vis      <= '0;
      r_valid    <= 1'b0;
      r_is_alien <= 1'b0;
      r_slot     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_speed    <= '0;
    end else begin
      r_p_active <= (r_p_active & ~pRelease) | w_p_set;
      r_a_active <= (r_a_active & ~aRelease) | w_a_set;
      r_col      <= w_col_next;
      r_row      <= w_row_next;
      r_vis      <= w_vis_next;
      if (w_player_go)
        r_cool <= CDW'(COOLDOWN);
      else if (startOfFrame && r_cool != '0)
        r_cool <= r_cool - 1'b1;
      r_valid <= w_player_go | w_alien_go;
      if (w_player_go) begin
        r_is_alien <= 1'b0;
        r_slot     <= w_p_slot;
        r_x        <= playerTLX + 11'(PLAYER_XOFF);
        r_y        <= playerTLY;
        r_speed    <= 11'(PLAYER_SPEED);
      end else if (w_alien_go) begin
        r_is_alien <= 1'b1;
        r_slot     <= w_a_slot;
        r_x        <= w_ax;
        r_y        <= w_ay;
        r_speed    <= w_aspeed;
      end
    end
  end

  assign isActivePlayers = r_p_active;
  assign isActiveAliens  = r_a_active;
  assign launchValid     = r_valid;
  assign launchIsAlien   = r_is_alien;
  assign launchSlot      = r_slot;
  assign initialX        = r_x;
  assign initialY        = r_y;
  assign initialSpeed    = r_speed;
  assign colIdx          = r_col;
  assign rowIdx          = r_row;
  assign scanBusy        = (r_state != S_IDLE);

endmodule

// File: doc/rocket_pool_controller.md
# rocket_pool_controller

Parametrised rocket-slot allocator for the space-invaders game core. It launches rockets for one player and for the alien grid, managing P_SLOTS player and A_SLOTS alien rocket slots. Slot releases arrive from the collision and border logic; a scan FSM finds a live alien to shoot from. It drives a single shared launch bus (initial X/Y/speed plus a one-cycle launch strobe) into the per-slot rocket movers.

## Interface
- P_SLOTS, 2: player rocket slots (1..8)
- A_SLOTS, 4: alien rocket slots (1..8)
- COLS, 14: alien grid columns (2..16); CW = $clog2(COLS)
- ROWS, 6: alien grid rows (2..8); RW = $clog2(ROWS)
- CELL, 32: grid cell pitch in pixels (power of 2)
- PLAYER_SPEED, -128: player rocket speed, pixels/64 per frame
- PLAYER_XOFF, 32: player muzzle X offset from player TLX
- COOLDOWN, 8: frames between accepted player shots (0 = none)
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- playerFire  in  1  one-cycle fire request
- shootPulse  in  1  one-cycle alien shot request
- randCol  in  CW  random start column
- randSpeed  in  2  random alien speed select
- alienAlive  in  1  combinational grid lookup at (colIdx,rowIdx), valid same cycle
- playerTLX, playerTLY  in  11 signed  player top-left
- aliensTLX, aliensTLY  in  11 signed  grid top-left
- pRelease  in  P_SLOTS  per-slot clear (hit/border/collision)
- aRelease  in  A_SLOTS  per-slot clear
- isActivePlayers  out  P_SLOTS  slot-busy flags
- isActiveAliens  out  A_SLOTS  slot-busy flags
- launchValid  out  1  one-cycle launch strobe
- launchIsAlien  out  1  0 = player launch, 1 = alien launch
- launchSlot  out  3  slot index of the launch
- initialX, initialY, initialSpeed  out  11 signed  launch parameters, held until the next launch
- colIdx  out  CW  scan column
- rowIdx  out  RW  scan row
- scanBusy  out  1  FSM not IDLE

## Operation
- Releases: each cycle, active <= active & ~release, for both pools. Releases are applied in parallel with every other action. There is no priority chain.
- Allocation picks the lowest-index slot that is free in the pre-edge active vector. A slot released this cycle becomes allocatable next cycle.
- Player launch:
  - Condition: playerFire, a free player slot, and cooldown == 0.
  - Action: set the slot bit; X = playerTLX + PLAYER_XOFF; Y = playerTLY; speed = PLAYER_SPEED; cooldown <= COOLDOWN.
  - playerFire is dropped silently if no slot is free or cooldown is nonzero.
- Cooldown counter decrements on startOfFrame, saturating at 0.
- Alien FSM states: IDLE, SCAN, LAUNCH.
  - IDLE: on shootPulse, col <= min(randCol, COLS-1); row <= ROWS-1; visited <= 0; go to SCAN. shootPulse outside IDLE is ignored.
  - SCAN, alienAlive = 1: go to LAUNCH with col/row held.
  - SCAN, alienAlive = 0 and row > 0: row--.
  - SCAN, alienAlive = 0 and row == 0: row <= ROWS-1; col <= (col == COLS-1) ? 0 : col+1.
  - SCAN, every cell visited: visited++. When visited reaches COLS*ROWS-1 with no live cell, go to IDLE with no launch (empty grid).
  - LAUNCH: if no alien slot is free, drop the shot and go to IDLE. If a player launch occurs this cycle, stay in LAUNCH (player has bus priority). Otherwise set the lowest free alien slot; X = aliensTLX + CELL*col + CELL/2; Y = aliensTLY + CELL*row + CELL; speed = 32 << randSpeed (32/64/128/256); go to IDLE.
- Arithmetic is 11-bit two's complement and wraps mod 2^11. There is no clamping.

## Timing
- Reset values: all active flags 0; launchValid 0; launchIsAlien 0; launchSlot 0; initialX/Y/Speed 0; colIdx/rowIdx 0; FSM IDLE; cooldown 0; scanBusy 0.
- playerFire at edge n: the slot bit, launchValid and the launch parameters are visible after edge n+1 (1-cycle latency).
- Alien shot latency = 1 (IDLE→SCAN) + k scan cycles (k = cells checked until the first live one, starting at 1) + 1 (LAUNCH). Worst case COLS*ROWS+2 cycles.
- launchValid is high for exactly one cycle per launch. At most one launch per cycle.
- Reset mid-scan returns the FSM to IDLE immediately, with no launch.

## Test plan
- Reset, playerFire, PLAYER_XOFF=32, playerTLX=100, playerTLY=400 → next cycle launchValid=1, launchIsAlien=0, slot 0, X=132, Y=400, speed=-128, isActivePlayers=01.
- Second fire before COOLDOWN frames have elapsed → ignored. After 8 startOfFrame pulses → slot 1 allocated. A third fire with both slots busy → dropped. pRelease=01 → slot 0 reused next.
- Grid with only cell (3,2) alive, randCol=3 → scan visits rows 5,4,3,2. Launch from slot 0: X = TLX+112, Y = TLY+96, randSpeed=2 gives speed 128.
- Empty grid, shootPulse → scanBusy high for exactly COLS*ROWS cycles, then IDLE with no launchValid.
- All alien slots busy at LAUNCH → shot dropped, FSM in IDLE. Player fire coinciding with alien LAUNCH → player launches first, alien launches the following cycle.
- randCol=13, column 13 empty, column 0 live → scan wraps to column 0. aRelease and alien launch in the same cycle → the released bit clears, the launch takes a different free slot.
